// File: rtl/ppwm_pkg.sv
// ppwm_pkg: definitions shared by the ppwm core and its upstream programmer.
//   - PPWM_INSTR_WIDTH / PPWM_MEM_DEPTH: default instruction width and program
//     image depth. The core and the programmer must use the same values.
//   - prog_tx_state_e: serialiser FSM states of ppwm_prog_tx, also exposed on
//     its state_o debug port.
package ppwm_pkg;

    localparam int PPWM_INSTR_WIDTH = 6;
    localparam int PPWM_MEM_DEPTH   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } prog_tx_state_e;

endpackage

// File: rtl/ppwm_fifo.sv
// ppwm_fifo: small synchronous show-ahead FIFO.
//   clk   : clock
//   rst   : synchronous active-high reset (empties the FIFO)
//   push  : write wdata (ignored when full)
//   wdata : write data
//   pop   : drop the head entry (ignored when empty)
//   rdata : head entry, valid whenever !empty
//   full  : DEPTH entries held
//   empty : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module ppwm_fifo
    import ppwm_pkg::*;
#(
    parameter int WIDTH = PPWM_INSTR_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ppwm_prog_tx.sv
// ppwm_prog_tx: upstream programmer for the ppwm core.
// Buffers instruction words and serialises each onto the core's single-bit
// programming line: one high start bit, then INSTR_WIDTH data bits LSB first,
// then GAP_BITS low bit times. Each bit lasts BIT_CYCLES clocks. After
// MEM_DEPTH words have been sent the block parks in DONE until clear_i/rst.
//   clk        : clock
//   rst        : synchronous active-high reset
//   instr_i    : instruction word to send
//   valid_i    : instr_i valid
//   ready_o    : word can be accepted this cycle
//   clear_i    : synchronous abort/restart of the programming session
//   data_o     : serial programming line, idle low
//   busy_o     : frame in flight or words buffered
//   word_cnt_o : words fully transmitted
//   done_o     : MEM_DEPTH words transmitted (sticky until clear_i/rst)
//   state_o    : serialiser FSM state (debug)
//
// Handshake: a word transfers on every posedge where valid_i && ready_o.
// The sender must keep valid_i and instr_i stable until that transfer;
// ready_o never depends on valid_i. A word offered while clear_i is high is
// discarded.
module ppwm_prog_tx
    import ppwm_pkg::*;
#(
    parameter int INSTR_WIDTH = PPWM_INSTR_WIDTH,
    parameter int MEM_DEPTH   = PPWM_MEM_DEPTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int BIT_CYCLES  = 1,
    parameter int GAP_BITS    = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INSTR_WIDTH-1:0]           instr_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic                             clear_i,
    output logic                             data_o,
    output logic                             busy_o,
    output logic [$clog2(MEM_DEPTH+1)-1:0]   word_cnt_o,
    output logic                             done_o,
    output prog_tx_state_e                   state_o
);

    localparam int CNT_W   = $clog2(MEM_DEPTH+1);
    localparam int PRE_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_MAX = (INSTR_WIDTH > GAP_BITS) ? INSTR_WIDTH : GAP_BITS;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(INSTR_WIDTH - 1);
    localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);
    localparam logic [CNT_W-1:0] IMAGE_LEN = CNT_W'(MEM_DEPTH);

    prog_tx_state_e          state;
    logic [PRE_W-1:0]        pre_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [INSTR_WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]        acc_cnt;
    logic [CNT_W-1:0]        word_cnt;

    logic                    fifo_rst;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [INSTR_WIDTH-1:0]  fifo_rdata;
    logic                    push;
    logic                    pop;
    logic                    bit_end;

    // acc_cnt caps accepted words at one image, which also caps word_cnt.
    assign ready_o  = !fifo_full && (acc_cnt < IMAGE_LEN) && (state != DONE);
    assign push     = valid_i && ready_o && !clear_i;
    assign pop      = (state == IDLE) && !fifo_empty && !clear_i;
    assign fifo_rst = rst || clear_i;
    assign bit_end  = (pre_cnt == PRE_LAST);

    ppwm_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (fifo_rst),
        .push  (push),
        .wdata (instr_i),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state    <= IDLE;
            pre_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            acc_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (push) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= fifo_rdata;
                        pre_cnt <= '0;
                        bit_idx <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        pre_cnt <= '0;
                        state   <= DATA;
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        pre_cnt <= '0;
                        // data_o always shows shreg[0]; shifting walks LSB first.
                        shreg   <= shreg >> 1;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx  <= '0;
                            word_cnt <= word_cnt + 1'b1;
                            state    <= GAP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (bit_end) begin
                        pre_cnt <= '0;
                        if (bit_idx == GAP_LAST) begin
                            bit_idx <= '0;
                            state   <= (word_cnt == IMAGE_LEN) ? DONE : IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign data_o     = (state == START) || ((state == DATA) && shreg[0]);
    assign busy_o     = (state == START) || (state == DATA) || (state == GAP) || !fifo_empty;
    assign word_cnt_o = word_cnt;
    assign done_o     = (state == DONE);
    assign state_o    = state;

endmodule

// File: tb/tb_ppwm_prog_tx.sv
// Bench for ppwm_prog_tx. Two instances: defaults (dut) and BIT_CYCLES=3 (dut3).
// Inputs change 1 time unit after posedge; the serial monitor samples at negedge.
module tb_ppwm_prog_tx;
    import ppwm_pkg::*;

    localparam int W = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default-parameter instance
    logic [W-1:0]   instr_i;
    logic           valid_i;
    logic           clear_i;
    logic           ready_o;
    logic           data_o;
    logic           busy_o;
    logic [4:0]     word_cnt_o;
    logic           done_o;
    prog_tx_state_e state_o;

    // BIT_CYCLES=3 instance
    logic [W-1:0]   instr3;
    logic           valid3;
    logic           clear3;
    logic           ready3;
    logic           data3;
    logic           busy3;
    logic [4:0]     word_cnt3;
    logic           done3;
    prog_tx_state_e state3;

    ppwm_prog_tx dut (
        .clk        (clk),
        .rst        (rst),
        .instr_i    (instr_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .clear_i    (clear_i),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .word_cnt_o (word_cnt_o),
        .done_o     (done_o),
        .state_o    (state_o)
    );

    ppwm_prog_tx #(.BIT_CYCLES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .instr_i    (instr3),
        .valid_i    (valid3),
        .ready_o    (ready3),
        .clear_i    (clear3),
        .data_o     (data3),
        .busy_o     (busy3),
        .word_cnt_o (word_cnt3),
        .done_o     (done3),
        .state_o    (state3)
    );

    // ---------------- scoreboard / reference model ----------------
    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];       // accepted words not yet seen on the line
    int           mon_phase;      // 0 idle, 1..W data bits, W+1 gap
    int           words_done;     // frames decoded since last reset/clear
    int           acc_total;      // words accepted since last reset/clear
    int           first_block_acc;
    logic [W-1:0] mon_word;
    logic         done_model;
    logic         last_accept;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decodes the serial line of dut (1 clock per bit) and models acceptance.
    task automatic monitor();
        last_accept = 1'b0;
        if (rst || clear_i) begin
            exp_q.delete();
            mon_phase       = 0;
            words_done      = 0;
            acc_total       = 0;
            done_model      = 1'b0;
            first_block_acc = -1;
            return;
        end
        check("done_flag", done_o, done_model);
        if (acc_total == 16 || done_model) begin
            check("ready_closed", ready_o, 0);
        end
        if (mon_phase == 0) begin
            if (data_o) mon_phase = 1;
        end else if (mon_phase == W + 1) begin
            check("gap_low", data_o, 0);
            check("word_cnt_at_gap", word_cnt_o, words_done);
            if (words_done == 16) done_model = 1'b1;
            mon_phase = 0;
        end else begin
            mon_word[mon_phase-1] = data_o;
            mon_phase++;
            if (mon_phase == W + 1) begin
                words_done++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL decoded_word: got %0h expected none (nothing queued)", mon_word);
                end else begin
                    check("decoded_word", mon_word, exp_q.pop_front());
                end
            end
        end
        if (valid_i && ready_o) begin
            check("accept_limit", (acc_total < 16), 1);
            exp_q.push_back(instr_i);
            acc_total++;
            last_accept = 1'b1;
        end else if (valid_i && first_block_acc < 0) begin
            first_block_acc = acc_total;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] instr;
        logic [7:0]   wave;   // wave[k] = data_o k cycles after the start bit begins
    } vec_t;

    vec_t          vecs[5];
    logic [7:0]    wave;
    logic [23:0]   wave3;
    logic [4:0]    cnt_before;
    logic [4:0]    cnt_after;
    int            cyc;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{6'b101101, 8'b01011011};
        vecs[1] = '{6'b000000, 8'b00000001};
        vecs[2] = '{6'b111111, 8'b01111111};
        vecs[3] = '{6'b100001, 8'b01000011};
        vecs[4] = '{6'b010110, 8'b00101101};

        rst = 1'b1; valid_i = 1'b0; instr_i = '0; clear_i = 1'b0;
        valid3 = 1'b0; instr3 = '0; clear3 = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst_data", data_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_word_cnt", word_cnt_o, 0);
        check("rst_done", done_o, 0);
        check("rst_state", state_o, IDLE);
        check("rst_ready3", ready3, 1);
        check("rst_data3", data3, 0);

        // single-word frames from the table
        for (int i = 0; i < 5; i++) begin
            check("ready_before_push", ready_o, 1);
            instr_i = vecs[i].instr;
            valid_i = 1'b1;
            step();
            valid_i = 1'b0;
            check("pop_cycle_busy", busy_o, 1);
            check("pop_cycle_line", data_o, 0);
            wave = '0;
            for (int k = 0; k < 8; k++) begin
                step();
                wave[k] = data_o;
                if (k == 6) cnt_before = word_cnt_o;
                if (k == 7) cnt_after = word_cnt_o;
            end
            check("frame_wave", wave, vecs[i].wave);
            check("cnt_last_bit", cnt_before, i);
            check("cnt_gap", cnt_after, i + 1);
            step();
            check("busy_after_frame", busy_o, 0);
        end

        // clear during DATA bit 3 with two words queued
        for (int i = 0; i < 3; i++) begin
            instr_i = W'($urandom_range(0, 63));
            valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        step();
        step();
        step();
        check("clear_state_before", state_o, DATA);
        clear_i = 1'b1;
        valid_i = 1'b1;              // offered together with clear: must be dropped
        instr_i = W'($urandom_range(0, 63));
        step();
        clear_i = 1'b0;
        valid_i = 1'b0;
        check("clear_data", data_o, 0);
        check("clear_word_cnt", word_cnt_o, 0);
        check("clear_busy", busy_o, 0);
        check("clear_ready", ready_o, 1);
        check("clear_done", done_o, 0);
        step();
        check("clear_still_idle", busy_o, 0);

        instr_i = 6'b110010;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        wave = '0;
        for (int k = 0; k < 8; k++) begin
            step();
            wave[k] = data_o;
        end
        check("post_clear_wave", wave, 8'b01100101);
        check("post_clear_cnt", word_cnt_o, 1);

        // full image with valid held high from reset (backpressure)
        rst = 1'b1;
        valid_i = 1'b1;
        instr_i = W'($urandom_range(0, 63));
        step();
        rst = 1'b0;
        cyc = 0;
        while (!done_o && cyc < 400) begin
            step();
            cyc++;
            if (last_accept) instr_i = W'($urandom_range(0, 63));
        end
        check("image1_done", done_o, 1);
        check("image1_first_block", first_block_acc, 5);
        for (int k = 0; k < 12; k++) step();
        check("image1_accepted", acc_total, 16);
        check("image1_word_cnt", word_cnt_o, 16);
        check("image1_queue_empty", exp_q.size(), 0);
        check("image1_done_sticky", done_o, 1);
        check("image1_line_low", data_o, 0);

        // reset while in DONE, then a second session with random gaps
        valid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_done_cleared", done_o, 0);
        check("rst_cnt_cleared", word_cnt_o, 0);
        check("rst_ready_open", ready_o, 1);
        check("rst_busy_clear", busy_o, 0);
        cyc = 0;
        while (!done_o && cyc < 1500) begin
            if (!valid_i || last_accept) begin
                valid_i = ($urandom_range(0, 2) != 0);
                instr_i = W'($urandom_range(0, 63));
            end
            step();
            cyc++;
        end
        valid_i = 1'b0;
        check("image2_done", done_o, 1);
        step();
        step();
        check("image2_accepted", acc_total, 16);
        check("image2_word_cnt", word_cnt_o, 16);
        check("image2_queue_empty", exp_q.size(), 0);

        // BIT_CYCLES=3 instance: start + bit0 high for 6 cycles, then 18 low
        instr3 = 6'b000001;
        valid3 = 1'b1;
        step();
        valid3 = 1'b0;
        check("bc3_pop_line", data3, 0);
        wave3 = '0;
        for (int k = 0; k < 24; k++) begin
            step();
            wave3[k] = data3;
            if (k == 20) cnt_before = word_cnt3;
            if (k == 21) cnt_after = word_cnt3;
        end
        check("bc3_wave", wave3, 24'h00003F);
        check("bc3_cnt_last_bit", cnt_before, 0);
        check("bc3_cnt_gap", cnt_after, 1);
        check("bc3_busy_in_gap", busy3, 1);
        step();
        check("bc3_busy_idle", busy3, 0);
        check("bc3_state_idle", state3, IDLE);
        check("bc3_ready", ready3, 1);
        check("bc3_done", done3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
